snn_seq: RTL and testbench

SNN_SEQ -- requirements
Module: snn_seq

---
 rtl/snn_seq.sv | 156 +++++++++++++++
 tb/tb_snn_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/snn_seq.sv
// rtl/snn_seq.sv - per-image sequencer for the SNN core (init, step/STDP loop, count, rest).
// Define SNN_SEQ_TIMEOUT_EN to enable the SYN_WAIT/STDP handshake timeout into ERR.
module snn_seq #(
   parameter int T_STEPS  = 100,
   parameter int FM_LAT   = 20,
   parameter int REST_CYC = 64,
   parameter int WAIT_MAX = 1023
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic       i_mode,
   input  logic       i_abort,
   input  logic [7:0] i_syn_done,
   input  logic [7:0] i_inh_valid,
   input  logic [7:0] i_stdp_done,
   input  logic [7:0] i_winner,
   output logic       o_run,
   output logic       o_rest_run,
   output logic       o_init,
   output logic       o_cnt_en,
   output logic       o_cnt_clr,
   output logic       o_stdp_run,
   output logic       o_s_stdp,
   output logic       o_sub,
   output logic       o_s_lern,
   output logic       o_s_infr,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err,
   output logic [7:0] o_result
);
   localparam int SC_W   = $clog2(T_STEPS + 1);
   localparam int WC_W   = $clog2(WAIT_MAX + 1);
   localparam int PH_MAX = (FM_LAT > REST_CYC) ? FM_LAT : REST_CYC;
   localparam int PC_W   = $clog2(PH_MAX + 1);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_INIT     = 4'd1;
   localparam logic [3:0] S_STEP     = 4'd2;
   localparam logic [3:0] S_SYN_WAIT = 4'd3;
   localparam logic [3:0] S_STDP     = 4'd4;
   localparam logic [3:0] S_COUNT    = 4'd5;
   localparam logic [3:0] S_REST     = 4'd6;
   localparam logic [3:0] S_DONE     = 4'd7;
   localparam logic [3:0] S_ERR      = 4'd8;

   logic [3:0]      state, state_nxt;
   logic            mode, mode_nxt;
   logic [SC_W-1:0] step_cnt, step_nxt, step_inc;
   logic [WC_W-1:0] wait_cnt;
   logic [PC_W-1:0] ph_cnt;
   logic            syn_ok, stdp_ok, wait_exp, busy_nxt;

   always_comb begin
      state_nxt = state;
      mode_nxt  = mode;
      step_nxt  = step_cnt;
      syn_ok    = (i_syn_done == 8'hFF) && (i_inh_valid == 8'hFF);
      stdp_ok   = (i_stdp_done == 8'hFF);
      step_inc  = (step_cnt == SC_W'(T_STEPS)) ? step_cnt : step_cnt + 1'b1;
`ifdef SNN_SEQ_TIMEOUT_EN
      wait_exp  = (wait_cnt == WC_W'(WAIT_MAX));
`else
      wait_exp  = 1'b0;
`endif
      case (state)
         S_IDLE, S_ERR: if (i_start) begin
            mode_nxt  = i_mode;
            state_nxt = S_INIT;
         end
         S_INIT: begin
            step_nxt  = '0;
            state_nxt = S_STEP;
         end
         S_STEP: state_nxt = S_SYN_WAIT;
         S_SYN_WAIT: begin
            if (syn_ok) begin
               if (!mode) begin
                  state_nxt = S_STDP;
               end else begin
                  step_nxt  = step_inc;
                  state_nxt = (step_inc == SC_W'(T_STEPS)) ? S_COUNT : S_STEP;
               end
            end else if (wait_exp) begin
               state_nxt = S_ERR;
            end
         end
         S_STDP: begin
            if (stdp_ok) begin
               step_nxt  = step_inc;
               state_nxt = (step_inc == SC_W'(T_STEPS)) ? S_COUNT : S_STEP;
            end else if (wait_exp) begin
               state_nxt = S_ERR;
            end
         end
         S_COUNT: if (ph_cnt == PC_W'(FM_LAT)) state_nxt = S_REST;
         S_REST:  if (ph_cnt == PC_W'(REST_CYC - 1)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (i_abort) state_nxt = S_IDLE;
      busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_ERR);
   end

   // Outputs are decoded from the next state so every one of them is a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         mode       <= 1'b0;
         step_cnt   <= '0;
         wait_cnt   <= '0;
         ph_cnt     <= '0;
         o_run      <= 1'b0;
         o_rest_run <= 1'b0;
         o_init     <= 1'b0;
         o_cnt_en   <= 1'b0;
         o_cnt_clr  <= 1'b0;
         o_stdp_run <= 1'b0;
         o_s_stdp   <= 1'b0;
         o_sub      <= 1'b0;
         o_s_lern   <= 1'b0;
         o_s_infr   <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
         o_result   <= 8'h00;
      end else begin
         state    <= state_nxt;
         mode     <= mode_nxt;
         step_cnt <= step_nxt;
         if (state_nxt != state)                 wait_cnt <= '0;
         else if (wait_cnt != WC_W'(WAIT_MAX))   wait_cnt <= wait_cnt + 1'b1;
         if (state_nxt != state)                 ph_cnt <= '0;
         else if (ph_cnt != PC_W'(PH_MAX))       ph_cnt <= ph_cnt + 1'b1;
         o_run      <= (state_nxt == S_STEP);
         o_init     <= (state_nxt == S_INIT);
         o_cnt_clr  <= (state_nxt == S_INIT);
         o_cnt_en   <= (state_nxt == S_COUNT) && (state != S_COUNT);
         o_rest_run <= (state_nxt == S_REST) && (state != S_REST);
         o_stdp_run <= (state_nxt == S_STDP);
         o_s_stdp   <= (state_nxt == S_STDP);
         o_sub      <= (state_nxt == S_STDP);
         o_busy     <= busy_nxt;
         o_s_lern   <= busy_nxt && !mode_nxt;
         o_s_infr   <= busy_nxt && mode_nxt;
         o_done     <= (state_nxt == S_DONE);
`ifdef SNN_SEQ_TIMEOUT_EN
         o_err      <= (state_nxt == S_ERR);
`else
         o_err      <= 1'b0;
`endif
         if (state == S_COUNT && state_nxt == S_REST) o_result <= i_winner;
      end
   end
endmodule

// File: tb/tb_snn_seq.sv
// tb/tb_snn_seq.sv - directed self-checking bench for snn_seq (T_STEPS=4, WAIT_MAX=15).
module tb_snn_seq;
   localparam int T_STEPS  = 4;
   localparam int FM_LAT   = 5;
   localparam int REST_CYC = 8;
   localparam int WAIT_MAX = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_start = 1'b0, i_mode = 1'b0, i_abort = 1'b0;
   logic [7:0] i_syn_done, i_inh_valid, i_stdp_done;
   logic [7:0] i_winner = 8'd0;
   logic       o_run, o_rest_run, o_init, o_cnt_en, o_cnt_clr;
   logic       o_stdp_run, o_s_stdp, o_sub, o_s_lern, o_s_infr;
   logic       o_busy, o_done, o_err;
   logic [7:0] o_result;

   logic       auto_resp = 1'b0;
   logic [7:0] r_syn = 8'h00, r_inh = 8'h00, r_stdp = 8'h00;
   logic [7:0] m_syn = 8'h00, m_inh = 8'h00, m_stdp = 8'h00;

   int n_checks = 0, n_errors = 0;
   int run_cnt, stdp_rise, cnt_en_cnt, done_cnt, init_cnt, clr_cnt, rest_cnt;
   int stdp_hi, infr_hi, lern_hi, infr_miss, cyc, rest_cyc, done_cyc;

   assign i_syn_done  = auto_resp ? r_syn  : m_syn;
   assign i_inh_valid = auto_resp ? r_inh  : m_inh;
   assign i_stdp_done = auto_resp ? r_stdp : m_stdp;

   snn_seq #(.T_STEPS(T_STEPS), .FM_LAT(FM_LAT), .REST_CYC(REST_CYC), .WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode), .i_abort(i_abort),
      .i_syn_done(i_syn_done), .i_inh_valid(i_inh_valid), .i_stdp_done(i_stdp_done),
      .i_winner(i_winner), .o_run(o_run), .o_rest_run(o_rest_run), .o_init(o_init),
      .o_cnt_en(o_cnt_en), .o_cnt_clr(o_cnt_clr), .o_stdp_run(o_stdp_run), .o_s_stdp(o_s_stdp),
      .o_sub(o_sub), .o_s_lern(o_s_lern), .o_s_infr(o_s_infr), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err), .o_result(o_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic clr_stats();
      run_cnt = 0; stdp_rise = 0; cnt_en_cnt = 0; done_cnt = 0; init_cnt = 0; clr_cnt = 0;
      rest_cnt = 0; stdp_hi = 0; infr_hi = 0; lern_hi = 0; infr_miss = 0;
      rest_cyc = 0; done_cyc = 0;
   endtask

   task automatic start_img(input logic mode);
      i_start = 1'b1; i_mode = mode;
      @(negedge clk);
      i_start = 1'b0; i_mode = 1'b0;
   endtask

   task automatic wait_high(input string tag, input int sel, input int bound);
      int n = 0;
      while (n < bound && !(sel == 0 ? o_done : sel == 1 ? o_run : o_cnt_en)) begin
         @(negedge clk);
         n++;
      end
      chk(tag, n < bound, 1);
   endtask

   // Network stand-in: status returns all-ones two cycles after each request.
   initial begin
      int syn_dly = 0, stdp_dly = 0;
      logic prev_stdp = 1'b0;
      forever begin
         @(negedge clk);
         if (auto_resp) begin
            r_syn = 8'h00; r_inh = 8'h00; r_stdp = 8'h00;
            if (syn_dly == 1) begin r_syn = 8'hFF; r_inh = 8'hFF; end
            if (stdp_dly == 1) r_stdp = 8'hFF;
            if (syn_dly > 0) syn_dly--;
            if (stdp_dly > 0) stdp_dly--;
            if (o_run) syn_dly = 2;
            if (o_stdp_run && !prev_stdp) stdp_dly = 2;
         end
         prev_stdp = o_stdp_run;
      end
   end

   initial begin
      logic prev = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         run_cnt    += int'(o_run);
         cnt_en_cnt += int'(o_cnt_en);
         init_cnt   += int'(o_init);
         clr_cnt    += int'(o_cnt_clr);
         stdp_hi    += int'(o_stdp_run);
         infr_hi    += int'(o_s_infr);
         lern_hi    += int'(o_s_lern);
         if (o_busy && !o_s_infr) infr_miss++;
         if (o_stdp_run && !prev) stdp_rise++;
         if (o_rest_run) begin rest_cnt++; rest_cyc = cyc; end
         if (o_done) begin done_cnt++; done_cyc = cyc; end
         prev = o_stdp_run;
      end
   end

   initial begin
      int hold_hits;
      clr_stats();
      repeat (3) @(negedge clk);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_err", o_err, 0);
      chk("rst_result", o_result, 0);
      chk("rst_run", o_run, 0);
      chk("rst_lern", o_s_lern, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Learn image, with a stray i_start (infer) mid-image that must be ignored.
      auto_resp = 1'b1; i_winner = 8'd37;
      clr_stats();
      start_img(1'b0);
      repeat (10) @(negedge clk);
      start_img(1'b1);
      wait_high("learn_done_seen", 0, 1000);
      repeat (3) @(negedge clk);
      chk("learn_runs", run_cnt, T_STEPS);
      chk("learn_stdp_windows", stdp_rise, T_STEPS);
      chk("learn_cnt_en", cnt_en_cnt, 1);
      chk("learn_init", init_cnt, 1);
      chk("learn_cnt_clr", clr_cnt, 1);
      chk("learn_rest_run", rest_cnt, 1);
      chk("learn_done", done_cnt, 1);
      chk("learn_result", o_result, 37);
      chk("learn_infr_never", infr_hi, 0);
      chk("learn_busy_after", o_busy, 0);

      // Infer image.
      i_winner = 8'd200;
      clr_stats();
      start_img(1'b1);
      wait_high("infer_done_seen", 0, 1000);
      repeat (3) @(negedge clk);
      chk("infer_stdp_hi", stdp_hi, 0);
      chk("infer_infr_gap", infr_miss, 0);
      chk("infer_infr_seen", infr_hi > 0, 1);
      chk("infer_lern_never", lern_hi, 0);
      chk("infer_runs", run_cnt, T_STEPS);
      chk("infer_done", done_cnt, 1);
      chk("infer_rest_len", done_cyc - rest_cyc, REST_CYC);
      chk("infer_result", o_result, 200);

      // Partial handshake: inh_valid 7F must hold the sequencer in SYN_WAIT.
      auto_resp = 1'b0;
      clr_stats();
      start_img(1'b0);
      wait_high("hold_run_seen", 1, 50);
      m_syn = 8'hFF; m_inh = 8'h7F;
      hold_hits = 0;
      repeat (10) begin
         @(negedge clk);
         hold_hits += int'(o_stdp_run);
      end
      chk("hold_no_advance", hold_hits, 0);
      chk("hold_busy", o_busy, 1);
      m_inh = 8'hFF;
      @(negedge clk);
      chk("hold_advance", o_stdp_run, 1);
      m_syn = 8'h00; m_inh = 8'h00;

      // Abort on the same cycle STDP completes.
      m_stdp = 8'hFF; i_abort = 1'b1;
      @(negedge clk);
      m_stdp = 8'h00; i_abort = 1'b0;
      chk("abort_stdp_run", o_stdp_run, 0);
      chk("abort_sub", o_sub, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_lern", o_s_lern, 0);
      repeat (20) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle", o_busy, 0);

      // Stuck handshake: timeout to ERR only when the feature is compiled in.
      clr_stats();
      start_img(1'b1);
      wait_high("stuck_run_seen", 1, 50);
      repeat (16) @(negedge clk);
      chk("stuck_err_early", o_err, 0);
      @(negedge clk);
`ifdef SNN_SEQ_TIMEOUT_EN
      chk("stuck_err", o_err, 1);
      chk("stuck_busy", o_busy, 0);
`else
      chk("stuck_err", o_err, 0);
      chk("stuck_busy", o_busy, 1);
`endif
      start_img(1'b0);
`ifdef SNN_SEQ_TIMEOUT_EN
      chk("restart_init", o_init, 1);
`else
      chk("restart_init", o_init, 0);
`endif
      chk("restart_err_clr", o_err, 0);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      chk("stuck_abort_busy", o_busy, 0);

      // Reset asserted during COUNT.
      auto_resp = 1'b1; i_winner = 8'd37;
      repeat (2) @(negedge clk);
      clr_stats();
      start_img(1'b0);
      wait_high("rst_cnt_en_seen", 2, 500);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", o_busy, 0);
      chk("arst_result", o_result, 0);
      chk("arst_lern", o_s_lern, 0);
      chk("arst_cnt_en", o_cnt_en, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("arst_no_done", done_cnt, 0);
      chk("arst_result_held", o_result, 0);
      chk("arst_idle", o_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
